// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: fetch-redirect bus between the pipeline (master) and the next-PC sequencer (slave).
interface pc_redirect_ctrl_if;
  logic [31:0] pc_cur, branch_target, isr_pc, ret_pc, pc_next, epc_out;
  logic im_stall, dm_stall, branch_taken, irq_req, mret_req;
  logic pc_write_en, flush_if_id, flush_id_ex, irq_ack, epc_we, in_isr;
  modport master (
    output pc_cur, im_stall, dm_stall, branch_taken, branch_target, irq_req, isr_pc, mret_req, ret_pc,
    input  pc_next, pc_write_en, flush_if_id, flush_id_ex, irq_ack, epc_we, epc_out, in_isr
  );
  modport slave (
    input  pc_cur, im_stall, dm_stall, branch_taken, branch_target, irq_req, isr_pc, mret_req, ret_pc,
    output pc_next, pc_write_en, flush_if_id, flush_id_ex, irq_ack, epc_we, epc_out, in_isr
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: next-PC sequencer (branch/trap/return arbitration, stall-held redirects).
// Optional PC_REDIR_STATS_EN adds saturating redirect/trap counters.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic clk,
  input logic reset,
  pc_redirect_ctrl_if.slave bus
`ifdef PC_REDIR_STATS_EN
  , output logic [31:0] redir_cnt_o
  , output logic [15:0] trap_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, DRAIN, ISR} state_t;
  state_t state_q, state_d;
  logic pend_v_q;
  logic [31:0] pend_tgt_q, epc_q, epc_d, pc_d;
  logic stall, trap, ret, redir;
  assign stall = bus.im_stall | bus.dm_stall;
  assign trap  = !stall && ((state_q == IDLE && bus.irq_req) || state_q == DRAIN);
  assign ret   = !stall && state_q == ISR && bus.mret_req;
  assign redir = !stall && (trap || ret || pend_v_q || bus.branch_taken);
  // EPC points at the oldest not-yet-applied control-flow target
  assign epc_d = pend_v_q ? pend_tgt_q : bus.branch_taken ? bus.branch_target : bus.pc_cur;
  assign pc_d  = trap ? bus.isr_pc : ret ? bus.ret_pc : pend_v_q ? pend_tgt_q :
                 bus.branch_taken ? bus.branch_target : bus.pc_cur + PC_STEP;
  always_comb begin
    state_d = state_q;
    if (trap) state_d = ISR;
    else if (ret) state_d = IDLE;
    else if (state_q == IDLE && bus.irq_req && stall) state_d = DRAIN;
  end
  assign bus.pc_next     = reset ? RESET_PC : pc_d;
  assign bus.pc_write_en = !reset && !stall;
  assign bus.flush_if_id = !reset && redir;
  assign bus.flush_id_ex = !reset && redir;
  assign bus.irq_ack     = !reset && trap;
  assign bus.epc_we      = !reset && trap;
  assign bus.epc_out     = epc_q;
  assign bus.in_isr      = state_q == ISR;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      epc_q      <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pend_v_q <= stall && (pend_v_q || bus.branch_taken);
      if (stall && !pend_v_q && bus.branch_taken) pend_tgt_q <= bus.branch_target;
      if (trap) epc_q <= epc_d;
    end
  end
`ifdef PC_REDIR_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_cnt_o <= '0;
      trap_cnt_o  <= '0;
    end else begin
      if (redir && !(&redir_cnt_o)) redir_cnt_o <= redir_cnt_o + 32'd1;
      if (trap && !(&trap_cnt_o)) trap_cnt_o <= trap_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed test-plan scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_redirect_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0;
  pc_redirect_ctrl_if bus ();
`ifdef PC_REDIR_STATS_EN
  logic [31:0] redir_cnt;
  logic [15:0] trap_cnt;
  pc_redirect_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .redir_cnt_o(redir_cnt), .trap_cnt_o(trap_cnt));
`else
  pc_redirect_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  // reference model: handler/draining flags and a one-deep queue of held branch targets
  bit m_handler, m_draining;
  logic [31:0] m_epc;
  logic [31:0] m_pend[$];
  logic [31:0] last_pc, last_epc;
  logic last_flush, last_ack, last_isr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_handler = 0;
    m_draining = 0;
    m_epc = RESET_PC;
    m_pend.delete();
  endtask
  task automatic drive(input bit im, input bit dm, input bit br, input logic [31:0] tgt,
                       input bit irq, input bit mret, input logic [31:0] pcc);
    bus.im_stall = im; bus.dm_stall = dm; bus.branch_taken = br; bus.branch_target = tgt;
    bus.irq_req = irq; bus.mret_req = mret; bus.pc_cur = pcc;
  endtask
  task automatic step();
    bit take_trap, take_ret, redir;
    logic [31:0] npc;
    @(negedge clk);
    last_pc = bus.pc_next; last_flush = bus.flush_if_id; last_ack = bus.irq_ack;
    last_isr = bus.in_isr; last_epc = bus.epc_out;
    if (reset) model_reset();
    chk("epc_out", bus.epc_out, m_epc);
    chk("in_isr", {31'd0, bus.in_isr}, {31'd0, m_handler});
    if (reset) begin
      chk("rst_pc", bus.pc_next, RESET_PC);
      chk("rst_strobes", {27'd0, bus.pc_write_en, bus.flush_if_id, bus.flush_id_ex, bus.irq_ack, bus.epc_we}, 32'd0);
    end else if (bus.im_stall || bus.dm_stall) begin
      chk("stall_strobes", {27'd0, bus.pc_write_en, bus.flush_if_id, bus.flush_id_ex, bus.irq_ack, bus.epc_we}, 32'd0);
      if (bus.branch_taken && m_pend.size() == 0) m_pend.push_back(bus.branch_target);
      if (!m_handler && bus.irq_req) m_draining = 1;
    end else begin
      take_trap = m_draining || (!m_handler && bus.irq_req);
      take_ret = m_handler && bus.mret_req;
      redir = take_trap || take_ret || m_pend.size() != 0 || bus.branch_taken;
      if (take_trap) begin
        npc = bus.isr_pc;
        m_epc = m_pend.size() != 0 ? m_pend[0] : bus.branch_taken ? bus.branch_target : bus.pc_cur;
        m_handler = 1;
        m_draining = 0;
      end else if (take_ret) begin
        npc = bus.ret_pc;
        m_handler = 0;
      end else if (m_pend.size() != 0) npc = m_pend[0];
      else if (bus.branch_taken) npc = bus.branch_target;
      else npc = bus.pc_cur + 32'd4;
      m_pend.delete();
      chk("pc_next", bus.pc_next, npc);
      chk("strobes", {27'd0, bus.pc_write_en, bus.flush_if_id, bus.flush_id_ex, bus.irq_ack, bus.epc_we},
          {27'd0, 1'b1, redir, redir, take_trap, take_trap});
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rnd_pc();
    return {$urandom(), 2'b00} & 32'hFFFF_FFFC;
  endfunction
  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 32'h100);
    bus.isr_pc = 32'h8000; bus.ret_pc = 32'h120;
    step(); step();
    reset = 1'b0;
    step();
    chk("tp_seq_pc", last_pc, 32'h104);
    chk("tp_seq_flush", {31'd0, last_flush}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC); step();
    chk("tp_wrap", last_pc, 32'h0);
    drive(1, 0, 1, 32'h200, 0, 0, 32'h104); step(); step(); step();
    drive(0, 0, 0, 0, 0, 0, 32'h104); step();
    chk("tp_br_held", last_pc, 32'h200);
    chk("tp_br_flush", {31'd0, last_flush}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 32'h200); step();
    chk("tp_pend_clr", last_pc, 32'h204);
    drive(0, 1, 1, 32'h300, 0, 0, 32'h204); step();
    drive(0, 1, 1, 32'h400, 0, 0, 32'h204); step();
    drive(0, 0, 0, 0, 0, 0, 32'h204); step();
    chk("tp_oldest", last_pc, 32'h300);
    drive(0, 1, 0, 0, 1, 0, 32'h120); step(); step();
    drive(0, 0, 0, 0, 1, 0, 32'h120); step();
    chk("tp_trap_pc", last_pc, 32'h8000);
    chk("tp_trap_ack", {31'd0, last_ack}, 32'd1);
    step();
    chk("tp_ack_once", {31'd0, last_ack}, 32'd0);
    chk("tp_in_isr", {31'd0, last_isr}, 32'd1);
    chk("tp_epc", last_epc, 32'h120);
    drive(0, 0, 0, 0, 1, 1, 32'h8008); step();
    chk("tp_ret_pc", last_pc, 32'h120);
    chk("tp_ret_noack", {31'd0, last_ack}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 32'h120); step();
    chk("tp_isr_exit", {31'd0, last_isr}, 32'd0);
    drive(0, 1, 1, 32'h500, 1, 0, 32'h200); step();
    reset = 1'b1; step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h200); step();
    chk("tp_rst_pc", last_pc, 32'h204);
    chk("tp_rst_flush", {31'd0, last_flush}, 32'd0);
    chk("tp_rst_epc", last_epc, RESET_PC);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, rnd_pc(),
            $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 19) == 0 ? 32'hFFFF_FFFC : rnd_pc());
      bus.isr_pc = rnd_pc();
      bus.ret_pc = rnd_pc();
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
